// File: rtl/mem_arbiter_pkg.sv
// Shared codes and state type for the memory-controller arbiter.
// Optional IF-starvation aging is enabled by defining MEM_ARB_AGING_EN.
package mem_arbiter_pkg;

   localparam logic [1:0] MC_KIND_NONE  = 2'b00;
   localparam logic [1:0] MC_KIND_IF    = 2'b01;
   localparam logic [1:0] MC_KIND_LOAD  = 2'b10;
   localparam logic [1:0] MC_KIND_STORE = 2'b11;

   localparam logic [1:0] SIZE_BYTE = 2'b01;
   localparam logic [1:0] SIZE_HALF = 2'b10;
   localparam logic [1:0] SIZE_WORD = 2'b11;

   // addr[17:16] of the memory-mapped UART window
   localparam logic [1:0] IO_ADDR_HI = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_WAIT,
      ST_DRAIN
   } arb_state_e;

   function automatic logic is_io_addr(input logic [1:0] addr_hi);
      return addr_hi == IO_ADDR_HI;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-controller bus of the arbiter.
// slave = arbiter view, master = requesters plus downstream controller.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_done;

   logic              lsb_req;
   logic              lsb_rw;
   logic [1:0]        lsb_size;
   logic [ADDR_W-1:0] lsb_addr;
   logic [DATA_W-1:0] lsb_wdata;
   logic              lsb_done;
   logic [DATA_W-1:0] lsb_rdata;

   logic              mc_valid;
   logic [1:0]        mc_kind;
   logic [ADDR_W-1:0] mc_addr;
   logic [1:0]        mc_size;
   logic [DATA_W-1:0] mc_wdata;
   logic              mc_accept;
   logic              mc_done;
   logic [DATA_W-1:0] mc_rdata;

   modport slave (
      input  if_req, if_addr,
      output if_done,
      input  lsb_req, lsb_rw, lsb_size, lsb_addr, lsb_wdata,
      output lsb_done, lsb_rdata,
      output mc_valid, mc_kind, mc_addr, mc_size, mc_wdata,
      input  mc_accept, mc_done, mc_rdata
   );

   modport master (
      output if_req, if_addr,
      input  if_done,
      output lsb_req, lsb_rw, lsb_size, lsb_addr, lsb_wdata,
      input  lsb_done, lsb_rdata,
      input  mc_valid, mc_kind, mc_addr, mc_size, mc_wdata,
      output mc_accept, mc_done, mc_rdata
   );

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational request picker: STORE > LOAD > IF, with a starved IF
// allowed to jump ahead of a LOAD (never ahead of an unblocked STORE).
module mem_arb_pick
   import mem_arbiter_pkg::*;
(
   input  logic       if_req_i,
   input  logic       lsb_req_i,
   input  logic       lsb_rw_i,
   input  logic [1:0] lsb_size_i,
   input  logic [1:0] lsb_addr_hi_i,
   input  logic       io_buffer_full_i,
   input  logic       roll_back_i,
   input  logic       if_starved_i,
   output logic [1:0] grant_kind_o
);

   logic size_ok;
   logic store_ok;
   logic load_ok;

   always_comb begin
      size_ok  = (lsb_size_i == SIZE_BYTE) || (lsb_size_i == SIZE_HALF) ||
                 (lsb_size_i == SIZE_WORD);
      // a store to the UART window waits while the UART cannot take it
      store_ok = lsb_req_i && lsb_rw_i && size_ok &&
                 !(is_io_addr(lsb_addr_hi_i) && io_buffer_full_i);
      load_ok  = lsb_req_i && !lsb_rw_i && size_ok && !roll_back_i;

      grant_kind_o = MC_KIND_NONE;
      if (store_ok) begin
         grant_kind_o = MC_KIND_STORE;
      end else if (if_req_i && if_starved_i) begin
         grant_kind_o = MC_KIND_IF;
      end else if (load_ok) begin
         grant_kind_o = MC_KIND_LOAD;
      end else if (if_req_i) begin
         grant_kind_o = MC_KIND_IF;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the byte-serial memory controller between IF refill, LSB load and LSB store.
// Define MEM_ARB_AGING_EN to stop IF starving behind a stream of LSB grants.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 4,
   parameter int CNT_W        = 3
) (
   input  logic         clk,
   input  logic         rst_in_n,
   input  logic         rdy_in,
   input  logic         roll_back,
   input  logic         io_buffer_full,
   mem_arbiter_if.slave bus
);

   // reset asserts immediately but leaves on a clock edge
   logic rst_meta_q;
   logic rst_n_q;

   always_ff @(posedge clk or negedge rst_in_n) begin
      if (!rst_in_n) begin
         rst_meta_q <= 1'b0;
         rst_n_q    <= 1'b0;
      end else begin
         rst_meta_q <= 1'b1;
         rst_n_q    <= rst_meta_q;
      end
   end

   arb_state_e        state_q, state_d;
   logic [1:0]        kind_q, kind_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        size_q, size_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              mc_valid_q, mc_valid_d;
   logic              if_done_q, if_done_d;
   logic              lsb_done_q, lsb_done_d;
   logic [DATA_W-1:0] rdata_q, rdata_d;

   logic [1:0] grant_kind;
   logic       grant_fire;
   logic       if_starved;
   logic       squash;

   mem_arb_pick u_pick (
      .if_req_i         (bus.if_req),
      .lsb_req_i        (bus.lsb_req),
      .lsb_rw_i         (bus.lsb_rw),
      .lsb_size_i       (bus.lsb_size),
      .lsb_addr_hi_i    (bus.lsb_addr[17:16]),
      .io_buffer_full_i (io_buffer_full),
      .roll_back_i      (roll_back),
      .if_starved_i     (if_starved),
      .grant_kind_o     (grant_kind)
   );

   // requesters drop their level request during the done pulse, so skip that cycle
   assign grant_fire = (state_q == ST_IDLE) && !if_done_q && !lsb_done_q &&
                       (grant_kind != MC_KIND_NONE);
   assign squash     = roll_back && (kind_q == MC_KIND_LOAD);

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      addr_d     = addr_q;
      size_d     = size_q;
      wdata_d    = wdata_q;
      mc_valid_d = mc_valid_q;
      if_done_d  = 1'b0;
      lsb_done_d = 1'b0;
      rdata_d    = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (grant_fire) begin
               state_d    = ST_ISSUE;
               mc_valid_d = 1'b1;
               kind_d     = grant_kind;
               if (grant_kind == MC_KIND_IF) begin
                  addr_d  = bus.if_addr;
                  size_d  = SIZE_WORD;
                  wdata_d = '0;
               end else begin
                  addr_d  = bus.lsb_addr;
                  size_d  = bus.lsb_size;
                  wdata_d = bus.lsb_wdata;
               end
            end
         end
         ST_ISSUE: begin
            if (squash) begin
               // a load taken in the same cycle is already in flight and must be drained
               mc_valid_d = 1'b0;
               state_d    = bus.mc_accept ? ST_DRAIN : ST_IDLE;
            end else if (bus.mc_accept) begin
               mc_valid_d = 1'b0;
               state_d    = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (bus.mc_done) begin
               state_d = ST_IDLE;
               if (!squash) begin
                  case (kind_q)
                     MC_KIND_IF: if_done_d = 1'b1;
                     MC_KIND_LOAD: begin
                        lsb_done_d = 1'b1;
                        rdata_d    = bus.mc_rdata;
                     end
                     MC_KIND_STORE: lsb_done_d = 1'b1;
                     default: ;
                  endcase
               end
            end else if (squash) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            if (bus.mc_done) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (state_d == ST_IDLE) begin
         kind_d = MC_KIND_NONE;
      end
   end

   always_ff @(posedge clk or negedge rst_n_q) begin
      if (!rst_n_q) begin
         state_q    <= ST_IDLE;
         kind_q     <= MC_KIND_NONE;
         addr_q     <= '0;
         size_q     <= '0;
         wdata_q    <= '0;
         mc_valid_q <= 1'b0;
         if_done_q  <= 1'b0;
         lsb_done_q <= 1'b0;
         rdata_q    <= '0;
      end else if (rdy_in) begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         addr_q     <= addr_d;
         size_q     <= size_d;
         wdata_q    <= wdata_d;
         mc_valid_q <= mc_valid_d;
         if_done_q  <= if_done_d;
         lsb_done_q <= lsb_done_d;
         rdata_q    <= rdata_d;
      end
   end

`ifdef MEM_ARB_AGING_EN
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] starve_q, starve_d;

   // counts LSB grants that overtook a waiting IF; saturates at the limit
   always_comb begin
      starve_d = starve_q;
      if (!bus.if_req) begin
         starve_d = '0;
      end else if (grant_fire && (grant_kind == MC_KIND_IF)) begin
         starve_d = '0;
      end else if (grant_fire && (starve_q != STARVE_MAX)) begin
         starve_d = starve_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n_q) begin
      if (!rst_n_q) begin
         starve_q <= '0;
      end else if (rdy_in) begin
         starve_q <= starve_d;
      end
   end

   assign if_starved = (starve_q >= STARVE_MAX);
`else
   assign if_starved = 1'b0;
`endif

   assign bus.mc_valid  = mc_valid_q;
   assign bus.mc_kind   = kind_q;
   assign bus.mc_addr   = addr_q;
   assign bus.mc_size   = size_q;
   assign bus.mc_wdata  = wdata_q;
   assign bus.if_done   = if_done_q;
   assign bus.lsb_done  = lsb_done_q;
   assign bus.lsb_rdata = rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: the bench plays requesters and the memory controller.
// Aging expectations switch with MEM_ARB_AGING_EN.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;

   logic clk = 1'b0;
   logic rst_in_n;
   logic rdy_in;
   logic roll_back;
   logic io_buffer_full;

   int n_checks = 0;
   int n_errors = 0;

   mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

   mem_arbiter #(
      .ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4), .CNT_W(3)
   ) dut (
      .clk            (clk),
      .rst_in_n       (rst_in_n),
      .rdy_in         (rdy_in),
      .roll_back      (roll_back),
      .io_buffer_full (io_buffer_full),
      .bus            (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (bus.mc_valid !== 1'b1 && n < 20) begin
         tick();
         n++;
      end
      check({tag, "_valid"}, 32'(bus.mc_valid), 32'd1);
   endtask

   // accept the command now, then pulse mc_done done_lat cycles later
   task automatic serve(input string tag, input int done_lat, input logic [31:0] rdata);
      $display("txn %s kind=%0d addr=0x%08h size=%0d wdata=0x%08h",
               tag, bus.mc_kind, bus.mc_addr, bus.mc_size, bus.mc_wdata);
      bus.mc_accept = 1'b1;
      tick();
      bus.mc_accept = 1'b0;
      check({tag, "_acc_drop"}, 32'(bus.mc_valid), 32'd0);
      repeat (done_lat - 1) tick();
      bus.mc_done  = 1'b1;
      bus.mc_rdata = rdata;
      tick();
      bus.mc_done  = 1'b0;
      bus.mc_rdata = '0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   logic [1:0] exp_kind [7];

   initial begin
      rst_in_n = 1'b0; rdy_in = 1'b1; roll_back = 1'b0; io_buffer_full = 1'b0;
      bus.if_req = 0; bus.if_addr = '0; bus.lsb_req = 0; bus.lsb_rw = 0;
      bus.lsb_size = '0; bus.lsb_addr = '0; bus.lsb_wdata = '0;
      bus.mc_accept = 0; bus.mc_done = 0; bus.mc_rdata = '0;

      // reset values
      tick(); tick();
      check("rst_valid", 32'(bus.mc_valid), 0);
      check("rst_kind", 32'(bus.mc_kind), 0);
      check("rst_if_done", 32'(bus.if_done), 0);
      check("rst_lsb_done", 32'(bus.lsb_done), 0);
      check("rst_rdata", bus.lsb_rdata, 0);
      rst_in_n = 1'b1;
      repeat (3) tick();

      // illegal size 00 is no request
      bus.lsb_req = 1; bus.lsb_rw = 0; bus.lsb_size = 2'b00; bus.lsb_addr = 32'h100;
      tick(); tick();
      check("size00_ignored", 32'(bus.mc_valid), 0);
      bus.lsb_req = 0;

      // 1: IF only
      bus.if_req = 1; bus.if_addr = 32'h1040;
      tick();
      check("t1_valid", 32'(bus.mc_valid), 1);
      check("t1_kind", 32'(bus.mc_kind), 32'(MC_KIND_IF));
      check("t1_addr", bus.mc_addr, 32'h1040);
      serve("t1", 5, 32'h0);
      check("t1_if_done", 32'(bus.if_done), 1);
      check("t1_lsb_done", 32'(bus.lsb_done), 0);
      bus.if_req = 0;
      tick();
      check("t1_if_done_pulse", 32'(bus.if_done), 0);
      check("t1_idle", 32'(bus.mc_valid), 0);

      // 2: IF and load together, load first
      bus.if_req = 1; bus.if_addr = 32'h2000;
      bus.lsb_req = 1; bus.lsb_rw = 0; bus.lsb_size = SIZE_WORD; bus.lsb_addr = 32'h200;
      tick();
      check("t2_kind", 32'(bus.mc_kind), 32'(MC_KIND_LOAD));
      check("t2_addr", bus.mc_addr, 32'h200);
      check("t2_size", 32'(bus.mc_size), 32'(SIZE_WORD));
      serve("t2ld", 3, 32'h12345678);
      check("t2_lsb_done", 32'(bus.lsb_done), 1);
      check("t2_rdata", bus.lsb_rdata, 32'h12345678);
      check("t2_if_done", 32'(bus.if_done), 0);
      bus.lsb_req = 0;
      tick();
      check("t2_done_gap", 32'(bus.mc_valid), 0);
      check("t2_lsb_pulse", 32'(bus.lsb_done), 0);
      tick();
      check("t2_if_valid", 32'(bus.mc_valid), 1);
      check("t2_if_kind", 32'(bus.mc_kind), 32'(MC_KIND_IF));
      check("t2_if_addr", bus.mc_addr, 32'h2000);
      serve("t2if", 2, 32'h0);
      check("t2_if_done2", 32'(bus.if_done), 1);
      bus.if_req = 0;
      tick();

      // 3: IO store held while UART full, IF served meanwhile
      io_buffer_full = 1;
      bus.lsb_req = 1; bus.lsb_rw = 1; bus.lsb_size = SIZE_BYTE;
      bus.lsb_addr = 32'h30000; bus.lsb_wdata = 32'hA5;
      bus.if_req = 1; bus.if_addr = 32'h3000;
      tick();
      check("t3_if_first", 32'(bus.mc_kind), 32'(MC_KIND_IF));
      serve("t3if", 2, 32'h0);
      check("t3_if_done", 32'(bus.if_done), 1);
      bus.if_req = 0;
      repeat (4) tick();
      check("t3_hold", 32'(bus.mc_valid), 0);
      io_buffer_full = 0;
      tick();
      check("t3_st_valid", 32'(bus.mc_valid), 1);
      check("t3_st_kind", 32'(bus.mc_kind), 32'(MC_KIND_STORE));
      check("t3_st_addr", bus.mc_addr, 32'h30000);
      check("t3_st_wdata", bus.mc_wdata, 32'hA5);
      check("t3_st_size", 32'(bus.mc_size), 32'(SIZE_BYTE));
      roll_back = 1;
      serve("t3st", 2, 32'h0);
      roll_back = 0;
      check("t3_st_done", 32'(bus.lsb_done), 1);
      bus.lsb_req = 0;
      tick();

      // 4: load squashed in WAIT, drained
      bus.lsb_req = 1; bus.lsb_rw = 0; bus.lsb_size = SIZE_HALF; bus.lsb_addr = 32'h400;
      tick();
      check("t4_kind", 32'(bus.mc_kind), 32'(MC_KIND_LOAD));
      bus.mc_accept = 1;
      tick();
      bus.mc_accept = 0;
      roll_back = 1; bus.lsb_req = 0;
      tick();
      roll_back = 0;
      tick(); tick();
      bus.mc_done = 1; bus.mc_rdata = 32'hDEADBEEF;
      tick();
      bus.mc_done = 0; bus.mc_rdata = '0;
      check("t4_no_done", 32'(bus.lsb_done), 0);
      tick();
      check("t4_no_done2", 32'(bus.lsb_done), 0);
      bus.lsb_req = 1; bus.lsb_addr = 32'h404;
      tick();
      check("t4_idle", 32'(bus.mc_valid), 1);
      serve("t4ld", 2, 32'hCAFEF00D);
      check("t4_done", 32'(bus.lsb_done), 1);
      check("t4_rdata", bus.lsb_rdata, 32'hCAFEF00D);
      bus.lsb_req = 0;
      tick();

      // 4b: load squashed while still in ISSUE
      bus.lsb_req = 1; bus.lsb_addr = 32'h500;
      tick();
      check("t4b_valid", 32'(bus.mc_valid), 1);
      roll_back = 1; bus.lsb_req = 0;
      tick();
      roll_back = 0;
      check("t4b_drop", 32'(bus.mc_valid), 0);
      repeat (2) tick();
      check("t4b_no_done", 32'(bus.lsb_done), 0);

      // 4c: roll_back together with mc_done goes straight to IDLE
      bus.lsb_req = 1; bus.lsb_addr = 32'h600;
      tick();
      check("t4c_valid", 32'(bus.mc_valid), 1);
      bus.mc_accept = 1;
      tick();
      bus.mc_accept = 0;
      tick();
      roll_back = 1; bus.mc_done = 1; bus.mc_rdata = 32'h11111111; bus.lsb_req = 0;
      tick();
      roll_back = 0; bus.mc_done = 0; bus.mc_rdata = '0;
      check("t4c_no_done", 32'(bus.lsb_done), 0);
      bus.if_req = 1; bus.if_addr = 32'h6000;
      tick();
      check("t4c_idle", 32'(bus.mc_valid), 1);
      check("t4c_kind", 32'(bus.mc_kind), 32'(MC_KIND_IF));
      serve("t4cif", 2, 32'h0);
      check("t4c_if_done", 32'(bus.if_done), 1);
      bus.if_req = 0;
      tick();

      // 5: six loads with IF waiting
`ifdef MEM_ARB_AGING_EN
      exp_kind = '{MC_KIND_LOAD, MC_KIND_LOAD, MC_KIND_LOAD, MC_KIND_LOAD,
                   MC_KIND_IF, MC_KIND_LOAD, MC_KIND_LOAD};
`else
      exp_kind = '{MC_KIND_LOAD, MC_KIND_LOAD, MC_KIND_LOAD, MC_KIND_LOAD,
                   MC_KIND_LOAD, MC_KIND_LOAD, MC_KIND_IF};
`endif
      begin
         int loads_left = 6;
         bus.if_req = 1; bus.if_addr = 32'h7000;
         bus.lsb_req = 1; bus.lsb_rw = 0; bus.lsb_size = SIZE_WORD; bus.lsb_addr = 32'h800;
         for (int g = 0; g < 7; g++) begin
            wait_valid($sformatf("t5_g%0d", g));
            check($sformatf("t5_kind%0d", g), 32'(bus.mc_kind), 32'(exp_kind[g]));
            serve($sformatf("t5_g%0d", g), 2, 32'h5000 + 32'(g));
            if (exp_kind[g] == MC_KIND_IF) begin
               check($sformatf("t5_if_done%0d", g), 32'(bus.if_done), 1);
               bus.if_req = 0;
            end else begin
               check($sformatf("t5_lsb_done%0d", g), 32'(bus.lsb_done), 1);
               loads_left--;
               bus.lsb_addr = bus.lsb_addr + 32'd4;
               if (loads_left == 0) bus.lsb_req = 0;
            end
            tick();
         end
      end

      // 6: async reset while a command is presented
      bus.if_req = 1; bus.if_addr = 32'h9000;
      tick();
      check("t6_valid", 32'(bus.mc_valid), 1);
      #2 rst_in_n = 1'b0;
      #1;
      check("t6_rst_valid", 32'(bus.mc_valid), 0);
      check("t6_rst_kind", 32'(bus.mc_kind), 0);
      bus.if_req = 0;
      tick();
      rst_in_n = 1'b1;
      repeat (3) tick();

      // 6: async reset mid-WAIT clears a pending done pulse at once
      bus.if_req = 1;
      tick();
      bus.mc_accept = 1;
      tick();
      bus.mc_accept = 0; bus.mc_done = 1;
      tick();
      bus.mc_done = 0;
      check("t6_done_before", 32'(bus.if_done), 1);
      #2 rst_in_n = 1'b0;
      #1;
      check("t6_rst_if_done", 32'(bus.if_done), 0);
      bus.if_req = 0;
      tick();
      rst_in_n = 1'b1;
      repeat (3) tick();

      // 6: rdy_in low freezes everything
      bus.lsb_req = 1; bus.lsb_rw = 1; bus.lsb_size = SIZE_WORD;
      bus.lsb_addr = 32'h100; bus.lsb_wdata = 32'h55;
      tick();
      check("t6_st_valid", 32'(bus.mc_valid), 1);
      rdy_in = 0; bus.mc_accept = 1;
      repeat (3) tick();
      check("t6_freeze_valid", 32'(bus.mc_valid), 1);
      rdy_in = 1;
      tick();
      check("t6_accepted", 32'(bus.mc_valid), 0);
      bus.mc_accept = 0; rdy_in = 0; bus.mc_done = 1;
      repeat (2) tick();
      check("t6_freeze_wait", 32'(bus.lsb_done), 0);
      rdy_in = 1;
      tick();
      check("t6_st_done", 32'(bus.lsb_done), 1);
      bus.mc_done = 0; rdy_in = 0;
      tick();
      check("t6_freeze_pulse", 32'(bus.lsb_done), 1);
      rdy_in = 1; bus.lsb_req = 0;
      tick();
      check("t6_pulse_end", 32'(bus.lsb_done), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
